rans_byte_packer: RTL and testbench

- Sits directly downstream of the rANS stream encoder stage.
- Consumes its per-cycle 0/1/2 renormalisation bytes (valid[1:0] + 16-bit enc) and packs them little-endian into WORD_BYTES-wide words.
- Buffers the words in a FIFO and presents them on a valid/ready master port with keep/last, so a DMA can stall without back-pressuring the encoder, which has no stall input.
- Flush terminates a stream with a last-marked word.

---
 rtl/rans_byte_packer.sv | 124 ++++++++++++
 tb/tb_rans_byte_packer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rans_byte_packer.sv
// Packs the rANS encoder's 0/1/2 bytes per cycle little-endian into words.
// Words sit in a FIFO behind a valid/ready master port, so a downstream stall never stalls the encoder.
module rans_byte_packer #(
  parameter int unsigned SYMBOL_WIDTH = 8,
  parameter int unsigned WORD_BYTES   = 4,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [1:0]                         valid_i,
  input  logic [2*SYMBOL_WIDTH-1:0]          enc_i,
  input  logic                               flush_i,
  output logic [WORD_BYTES*SYMBOL_WIDTH-1:0] m_data_o,
  output logic [WORD_BYTES-1:0]              m_keep_o,
  output logic                               m_last_o,
  output logic                               m_valid_o,
  input  logic                               m_ready_i,
  output logic [31:0]                        byte_count_o,
  output logic                               overflow_o,
  output logic                               error_o
);

  localparam int unsigned DataW = WORD_BYTES * SYMBOL_WIDTH;
  localparam int unsigned EntW  = DataW + WORD_BYTES + 1;
  localparam int unsigned FillW = $clog2(WORD_BYTES + 1);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);

  logic [FillW-1:0]                           fill_q, fill_d;
  logic [WORD_BYTES-1:0][SYMBOL_WIDTH-1:0]    acc_q, acc_d, word;
  logic                                       flush_pending_q, flush_pending_d;
  logic [31:0]                                byte_count_q;
  logic                                       overflow_q, error_q;
  logic [EntW-1:0]                            mem [FIFO_DEPTH];
  logic [PtrW:0]                              wptr_q, rptr_q;

  logic [1:0]              n;
  logic [SYMBOL_WIDTH-1:0] b0, b1;
  logic                    flush_eff, push, pop, full, empty, do_push;
  logic [WORD_BYTES-1:0]   keep_mask;
  logic [EntW-1:0]         push_entry, head;
  int unsigned             fill_int, total;

  always_comb begin
    b0 = enc_i[SYMBOL_WIDTH-1:0];
    b1 = enc_i[2*SYMBOL_WIDTH-1:SYMBOL_WIDTH];
    case (valid_i)
      2'b01:   n = 2'd1;
      2'b11:   n = 2'd2;
      default: n = 2'd0;
    endcase
    flush_eff = (valid_i == 2'b00) && (flush_pending_q || flush_i);
    fill_int  = 32'(fill_q);
    total     = fill_int + 32'(n);

    word      = acc_q;
    keep_mask = '0;
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      if (n != 2'd0 && i == fill_int) word[i] = b0;
      if (n == 2'd2 && i == fill_int + 1) word[i] = b1;
      keep_mask[i] = (i < fill_int);
    end

    acc_d      = word;
    fill_d     = FillW'(total);
    push       = 1'b0;
    push_entry = {1'b0, {WORD_BYTES{1'b1}}, word};
    if (flush_eff) begin
      push       = 1'b1;
      push_entry = {1'b1, keep_mask, acc_q};
      acc_d      = '0;
      fill_d     = '0;
    end else if (total >= WORD_BYTES) begin
      // A second byte that overruns the word starts the next accumulator.
      push   = 1'b1;
      acc_d  = '0;
      fill_d = FillW'(total - WORD_BYTES);
      if (total > WORD_BYTES) acc_d[0] = b1;
    end
    flush_pending_d = (flush_pending_q || flush_i) && !flush_eff;
  end

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                   (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign pop     = !empty && m_ready_i;
  assign do_push = push && (!full || pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr_q[PtrW-1:0]] <= push_entry;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fill_q          <= '0;
      acc_q           <= '0;
      flush_pending_q <= 1'b0;
      byte_count_q    <= '0;
      overflow_q      <= 1'b0;
      error_q         <= 1'b0;
      wptr_q          <= '0;
      rptr_q          <= '0;
    end else begin
      fill_q          <= fill_d;
      acc_q           <= acc_d;
      flush_pending_q <= flush_pending_d;
      byte_count_q    <= flush_eff ? '0 : byte_count_q + 32'(n);
      if (push && full && !pop) overflow_q <= 1'b1;
      if (valid_i == 2'b10) error_q <= 1'b1;
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
    end
  end

  // Head is gated while empty so outputs read zero out of reset.
  assign head         = mem[rptr_q[PtrW-1:0]];
  assign m_valid_o    = !empty;
  assign m_data_o     = empty ? '0 : head[DataW-1:0];
  assign m_keep_o     = empty ? '0 : head[DataW+WORD_BYTES-1:DataW];
  assign m_last_o     = empty ? 1'b0 : head[EntW-1];
  assign byte_count_o = byte_count_q;
  assign overflow_o   = overflow_q;
  assign error_o      = error_q;

endmodule

// File: tb/tb_rans_byte_packer.sv
// Bench for rans_byte_packer: directed vector table, stall/overflow sequence,
// and randomized traffic against a byte-queue reference model.
module tb_rans_byte_packer;
  localparam int WB = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  valid;
  logic [15:0] enc;
  logic        flush, ready;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last, m_valid;
  logic [31:0] byte_count;
  logic        overflow, error;

  rans_byte_packer #(.SYMBOL_WIDTH(8), .WORD_BYTES(WB), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .enc_i(enc), .flush_i(flush),
    .m_data_o(m_data), .m_keep_o(m_keep), .m_last_o(m_last), .m_valid_o(m_valid),
    .m_ready_i(ready), .byte_count_o(byte_count), .overflow_o(overflow), .error_o(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  v;
    logic [15:0] e;
    logic        f;
    logic        ev;
    logic [31:0] ed;
    logic [3:0]  ek;
    logic        el;
    logic [31:0] ec;
  } vec_t;
  vec_t tbl[$];

  task automatic addv(input logic [1:0] v, input logic [15:0] e, input logic f, input logic ev,
                      input logic [31:0] ed, input logic [3:0] ek, input logic el,
                      input logic [31:0] ec);
    vec_t r;
    r.v = v; r.e = e; r.f = f; r.ev = ev; r.ed = ed; r.ek = ek; r.el = el; r.ec = ec;
    tbl.push_back(r);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; valid = 2'b00; enc = '0; flush = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  // Reference model: bytes of the open word in a queue, output words in a queue.
  typedef struct { logic [31:0] d; logic [3:0] k; logic l; } ent_t;
  logic [7:0]  mq[$];
  ent_t        fq[$];
  logic        m_pend, m_ovf, m_err;
  logic [31:0] m_cnt;

  task automatic model_reset();
    mq.delete(); fq.delete();
    m_pend = 0; m_ovf = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    ent_t w;
    bit   have = 0;
    bit   pop  = (fq.size() > 0) && ready;
    bit   full = (fq.size() == DEPTH);
    w.d = 0; w.k = 0; w.l = 0;
    if (valid == 2'b10) m_err = 1;
    if (valid == 2'b00 && (m_pend || flush)) begin
      foreach (mq[i]) w.d[8*i+:8] = mq[i];
      w.k = 4'((1 << mq.size()) - 1);
      w.l = 1;
      have = 1;
      mq.delete();
      m_cnt = 0;
      m_pend = 0;
    end else begin
      m_pend = m_pend | flush;
      if (valid == 2'b01 || valid == 2'b11) begin mq.push_back(enc[7:0]); m_cnt++; end
      if (valid == 2'b11) begin mq.push_back(enc[15:8]); m_cnt++; end
      if (mq.size() >= WB) begin
        for (int i = 0; i < WB; i++) w.d[8*i+:8] = mq.pop_front();
        w.k = 4'hF;
        have = 1;
      end
    end
    if (pop) void'(fq.pop_front());
    if (have) begin
      if (!full || pop) fq.push_back(w);
      else m_ovf = 1;
    end
  endtask

  logic [31:0] exp_words[$];
  logic [31:0] held;

  initial begin
    ready = 1'b1;
    do_reset();
    chk("reset_valid", m_valid, 0);
    chk("reset_data", m_data, 0);
    chk("reset_keep", m_keep, 0);
    chk("reset_last", m_last, 0);
    chk("reset_count", byte_count, 0);
    chk("reset_flags", {overflow, error}, 0);

    addv(2'b01, 16'h0011, 0, 0, 0, 0, 0, 1);
    addv(2'b01, 16'h0022, 0, 0, 0, 0, 0, 2);
    addv(2'b01, 16'h0033, 0, 0, 0, 0, 0, 3);
    addv(2'b01, 16'h0044, 0, 1, 32'h44332211, 4'hF, 0, 4);
    addv(2'b11, 16'hBBAA, 0, 0, 0, 0, 0, 6);
    addv(2'b11, 16'hDDCC, 0, 1, 32'hDDCCBBAA, 4'hF, 0, 8);
    addv(2'b11, 16'hFFEE, 0, 0, 0, 0, 0, 10);
    addv(2'b00, 16'h0000, 1, 1, 32'h0000FFEE, 4'h3, 1, 0);
    addv(2'b00, 16'h0000, 1, 1, 32'h0, 4'h0, 1, 0);
    addv(2'b01, 16'h0011, 0, 0, 0, 0, 0, 1);
    addv(2'b01, 16'h0011, 0, 0, 0, 0, 0, 2);
    addv(2'b01, 16'h0011, 0, 0, 0, 0, 0, 3);
    addv(2'b01, 16'h0055, 1, 1, 32'h55111111, 4'hF, 0, 4);
    addv(2'b00, 16'h0000, 0, 1, 32'h0, 4'h0, 1, 0);
    addv(2'b10, 16'h9988, 0, 0, 0, 0, 0, 0);
    addv(2'b01, 16'h0077, 0, 0, 0, 0, 0, 1);
    addv(2'b00, 16'h0000, 1, 1, 32'h00000077, 4'h1, 1, 0);
    addv(2'b11, 16'h0201, 1, 0, 0, 0, 0, 2);
    addv(2'b11, 16'h0403, 1, 1, 32'h04030201, 4'hF, 0, 4);
    addv(2'b00, 16'h0000, 0, 1, 32'h0, 4'h0, 1, 0);
    addv(2'b00, 16'h0000, 0, 0, 0, 0, 0, 0);
    addv(2'b01, 16'h000A, 0, 0, 0, 0, 0, 1);
    addv(2'b01, 16'h000B, 0, 0, 0, 0, 0, 2);
    addv(2'b01, 16'h000C, 0, 0, 0, 0, 0, 3);
    addv(2'b11, 16'h0E0D, 0, 1, 32'h0D0C0B0A, 4'hF, 0, 5);
    addv(2'b00, 16'h0000, 1, 1, 32'h0000000E, 4'h1, 1, 0);
    addv(2'b00, 16'h0000, 0, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      valid = tbl[i].v; enc = tbl[i].e; flush = tbl[i].f;
      cyc();
      chk($sformatf("vec%0d_valid", i), m_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d_data", i), m_data, tbl[i].ed);
        chk($sformatf("vec%0d_keep", i), m_keep, tbl[i].ek);
        chk($sformatf("vec%0d_last", i), m_last, tbl[i].el);
      end
      chk($sformatf("vec%0d_count", i), byte_count, tbl[i].ec);
    end
    valid = 2'b00; flush = 1'b0;
    chk("error_sticky", error, 1);
    chk("no_overflow", overflow, 0);

    // Mid-stream reset must discard the open word.
    valid = 2'b01; enc = 16'h00AB;
    cyc();
    do_reset();
    chk("rst_clears_error", error, 0);
    chk("rst_count", byte_count, 0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("rst_term_valid", m_valid, 1);
    chk("rst_term_keep", m_keep, 0);
    chk("rst_term_last", m_last, 1);
    cyc();
    chk("rst_term_gone", m_valid, 0);

    // Stall with 17 words queued against a 16-entry FIFO.
    do_reset();
    ready = 1'b0;
    for (int w = 0; w < 17; w++) begin
      logic [7:0] b;
      b = 8'(4 * w);
      valid = 2'b11; enc = {b + 8'd1, b};
      cyc();
      enc = {b + 8'd3, b + 8'd2};
      cyc();
      exp_words.push_back({b + 8'd3, b + 8'd2, b + 8'd1, b});
    end
    valid = 2'b00;
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", byte_count, 68);
    held = m_data;
    for (int s = 0; s < 3; s++) begin
      cyc();
      chk($sformatf("stall_valid%0d", s), m_valid, 1);
      chk($sformatf("stall_hold%0d", s), m_data, exp_words[0]);
    end
    chk("stall_first_head", held, exp_words[0]);
    ready = 1'b1;
    for (int w = 0; w < 16; w++) begin
      chk($sformatf("drain_valid%0d", w), m_valid, 1);
      chk($sformatf("drain_data%0d", w), m_data, exp_words[w]);
      chk($sformatf("drain_keep%0d", w), m_keep, 4'hF);
      cyc();
    end
    chk("drain_empty", m_valid, 0);

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = $urandom_range(0, 15);
      if (r < 4) valid = 2'b00;
      else if (r < 9) valid = 2'b01;
      else if (r < 15 || c < 2000) valid = 2'b11;
      else valid = 2'b10;
      enc = 16'($urandom);
      flush = ($urandom_range(0, 19) == 0);
      if ((c % 600) < 300) ready = ($urandom_range(0, 3) != 0);
      else ready = ($urandom_range(0, 3) == 0);
      @(posedge clk);
      model_step();
      #1;
      chk("rnd_valid", m_valid, fq.size() != 0);
      if (fq.size() != 0) begin
        chk("rnd_data", m_data, fq[0].d);
        chk("rnd_keep", m_keep, fq[0].k);
        chk("rnd_last", m_last, fq[0].l);
      end
      chk("rnd_count", byte_count, m_cnt);
      chk("rnd_overflow", overflow, m_ovf);
      chk("rnd_error", error, m_err);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
